cam_wr_ctrl: RTL and testbench

CAM_WR_CTRL -- requirements
Module: cam_wr_ctrl

---
 rtl/cam_wr_ctrl_pkg.sv | 14 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/cam_wr_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cam_wr_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_wr_ctrl_pkg.sv
// Shared types and default sizing for the camera write controller.
package cam_wr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2
  } wr_state_t;

  localparam int unsigned DEF_BURST_LEN   = 8;
  localparam int unsigned DEF_FIFO_DEPTH  = 16;
  localparam int unsigned DEF_FRAME_WORDS = 307200;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock pixel FIFO with flush; a push in the flush cycle lands in the emptied FIFO.
module sync_fifo
  import cam_wr_ctrl_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout_c,
  output logic [CW-1:0] count,
  output logic          full_c,
  output logic          empty_c
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign dout_c  = mem[rd_ptr];
  assign pop_ok  = pop && !empty_c && !flush;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_ok = push && (flush || !full_c || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[flush ? AW'(0) : wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push_ok ? AW'(1) : AW'(0);
      count  <= push_ok ? CW'(1) : CW'(0);
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cam_wr_ctrl.sv
// Buffers camera pixels and issues fixed-length write bursts to memory, one frame per vsyn fall.
// Define CAM_PINGPONG_EN to alternate frames between bank 0 and BANK_OFFSET (adds wr_bank).
module cam_wr_ctrl
  import cam_wr_ctrl_pkg::*;
#(
  parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned       FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned       ADDR_W      = 22,
  parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [ADDR_W-1:0] BANK_OFFSET = ADDR_W'(22'h080000)
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  input  logic              cmos_vsyn,
  input  logic [15:0]       data_16b,
  input  logic              data_16b_en,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  output logic [15:0]       wr_data,
  output logic              wr_data_en,
  output logic              frame_done,
  output logic              ovf_err
`ifdef CAM_PINGPONG_EN
  ,
  output logic              wr_bank
`endif
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WCW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BCW = $clog2(BURST_LEN);

  wr_state_t         state;
  logic              vsyn_d1;
  logic              vsyn_d2;
  logic              pending;
  logic [BCW-1:0]    beat_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [15:0]       fifo_dout_c;
  logic              vsyn_neg_c;
  logic              flush_c;
  logic              pop_c;
  logic              last_beat_c;
  logic              frame_end_c;
  logic              bank_sel_c;
  logic [ADDR_W-1:0] bank_base_c;

  assign vsyn_neg_c  = vsyn_d2 & ~vsyn_d1;
  assign flush_c     = pending && (state == IDLE);
  assign pop_c       = (state == BURST);
  assign last_beat_c = (beat_cnt == BCW'(BURST_LEN - 1));
  assign frame_end_c = (word_cnt == WCW'(FRAME_WORDS - BURST_LEN));
`ifdef CAM_PINGPONG_EN
  assign bank_sel_c  = wr_bank;
`else
  assign bank_sel_c  = 1'b0;
`endif
  assign bank_base_c = bank_sel_c ? BANK_OFFSET : '0;

  sync_fifo #(
    .DW    (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (cmos_pclk),
    .rst_n   (rst_n),
    .flush   (flush_c),
    .push    (data_16b_en),
    .din     (data_16b),
    .pop     (pop_c),
    .dout_c  (fifo_dout_c),
    .count   (fifo_count),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // Frame sync edge detect, restart latch and sticky overflow.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsyn_d1 <= 1'b0;
      vsyn_d2 <= 1'b0;
      pending <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      vsyn_d1 <= cmos_vsyn;
      vsyn_d2 <= vsyn_d1;
      if (vsyn_neg_c)   pending <= 1'b1;
      else if (flush_c) pending <= 1'b0;
      if (data_16b_en && fifo_full_c && !pop_c && !flush_c) ovf_err <= 1'b1;
    end
  end

  // Burst sequencing, address and frame accounting.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      beat_cnt   <= '0;
      word_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_c) begin
            word_cnt <= '0;
            wr_addr  <= bank_base_c;
          end else if (!vsyn_neg_c && !fifo_empty_c && fifo_count >= FCW'(BURST_LEN)) begin
            state  <= REQ;
            wr_req <= 1'b1;
          end
        end
        REQ: begin
          if (wr_ack) begin
            state    <= BURST;
            wr_req   <= 1'b0;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          beat_cnt <= beat_cnt + BCW'(1);
          if (last_beat_c) begin
            state   <= IDLE;
            wr_addr <= wr_addr + ADDR_W'(BURST_LEN);
            if (frame_end_c) begin
              word_cnt   <= '0;
              frame_done <= 1'b1;
            end else begin
              word_cnt <= word_cnt + WCW'(BURST_LEN);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Popped word is presented one cycle after the pop.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_data    <= '0;
      wr_data_en <= 1'b0;
    end else begin
      wr_data_en <= pop_c;
      if (pop_c) wr_data <= fifo_dout_c;
    end
  end

`ifdef CAM_PINGPONG_EN
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n)          wr_bank <= 1'b0;
    else if (frame_done) wr_bank <= ~wr_bank;
  end
`endif

endmodule

// File: tb/tb_cam_wr_ctrl.sv
// Directed bench for cam_wr_ctrl (BURST_LEN=8, FIFO_DEPTH=16, FRAME_WORDS=16).
module tb_cam_wr_ctrl;

  logic        cmos_pclk   = 1'b0;
  logic        rst_n       = 1'b0;
  logic        cmos_vsyn   = 1'b0;
  logic [15:0] data_16b    = 16'h0;
  logic        data_16b_en = 1'b0;
  logic        wr_ack      = 1'b0;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_data_en;
  logic        frame_done;
  logic        ovf_err;
`ifdef CAM_PINGPONG_EN
  logic        wr_bank;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mon_q[$];
  int          mon_cyc[$];
  int          cyc    = 0;
  int          fd_cnt = 0;
  int          fd_idx = 0;
  logic        fd_en  = 1'b0;

  cam_wr_ctrl #(
    .BURST_LEN   (8),
    .FIFO_DEPTH  (16),
    .ADDR_W      (22),
    .FRAME_WORDS (16),
    .BANK_OFFSET (22'h080000)
  ) dut (
    .cmos_pclk   (cmos_pclk),
    .rst_n       (rst_n),
    .cmos_vsyn   (cmos_vsyn),
    .data_16b    (data_16b),
    .data_16b_en (data_16b_en),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_ack      (wr_ack),
    .wr_data     (wr_data),
    .wr_data_en  (wr_data_en),
    .frame_done  (frame_done),
    .ovf_err     (ovf_err)
`ifdef CAM_PINGPONG_EN
    ,
    .wr_bank     (wr_bank)
`endif
  );

  always #5 cmos_pclk = ~cmos_pclk;

  // Output monitor: records every write word and where frame_done landed.
  always @(negedge cmos_pclk) begin
    cyc++;
    if (rst_n) begin
      if (wr_data_en) begin
        mon_q.push_back(wr_data);
        mon_cyc.push_back(cyc);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_idx = mon_q.size();
        fd_en  = wr_data_en;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge cmos_pclk);
    #1;
  endtask

  task automatic clr_mon();
    mon_q.delete();
    mon_cyc.delete();
    fd_cnt = 0;
    fd_idx = 0;
    fd_en  = 1'b0;
  endtask

  task automatic send_px(input logic [15:0] v);
    data_16b    = v;
    data_16b_en = 1'b1;
    tick();
    data_16b_en = 1'b0;
  endtask

  task automatic vsyn_fall();
    cmos_vsyn = 1'b1;
    tick(3);
    cmos_vsyn = 1'b0;
    tick(4);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (wr_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack_burst(input int n, output int got);
    int start;
    start  = mon_q.size();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    for (int k = 0; k < 40 && (mon_q.size() - start) < n; k++) tick();
    tick(3);
    got = mon_q.size() - start;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    n_tests++; if (wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_wr_req: got %0b want 0", wr_req); end
    n_tests++; if (wr_addr !== 22'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    n_tests++; if (wr_data !== 16'h0) begin n_fail++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
    n_tests++; if (wr_data_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_data_en: got %0b want 0", wr_data_en); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
    n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_err: got %0b want 0", ovf_err); end
`ifdef CAM_PINGPONG_EN
    n_tests++; if (wr_bank !== 1'b0) begin n_fail++; $display("FAIL reset_wr_bank: got %0b want 0", wr_bank); end
`endif
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic_burst();
    bit ok;
    int got;
    logic [21:0] a;
    vsyn_fall();
    clr_mon();
    for (int i = 0; i < 8; i++) send_px(16'(i + 1));
    wait_req(ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_req1: wr_req seen %0b want 1", ok); end
    n_tests++; if (wr_addr !== 22'h0) begin n_fail++; $display("FAIL basic_addr1: got %0h want 0", wr_addr); end
    tick(5);
    n_tests++; if (wr_req !== 1'b1 || wr_addr !== 22'h0) begin n_fail++; $display("FAIL basic_req_hold: req %0b addr %0h want 1/0", wr_req, wr_addr); end
    ack_burst(8, got);
    n_tests++; if (got !== 8) begin n_fail++; $display("FAIL basic_beats1: got %0d want 8", got); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (mon_q[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL basic_data[%0d]: got %0h want %0h", i, mon_q[i], 16'(i + 1)); end
    end
    n_tests++; if (mon_cyc[7] - mon_cyc[0] !== 7) begin n_fail++; $display("FAIL basic_contig: span %0d want 7", mon_cyc[7] - mon_cyc[0]); end
    for (int i = 8; i < 16; i++) send_px(16'(i + 1));
    wait_req(ok);
    a = wr_addr;
    n_tests++; if (ok !== 1'b1 || a !== 22'h8) begin n_fail++; $display("FAIL basic_addr2: req %0b addr %0h want 1/8", ok, a); end
    ack_burst(8, got);
    n_tests++; if (got !== 8) begin n_fail++; $display("FAIL basic_beats2: got %0d want 8", got); end
    for (int i = 8; i < 16; i++) begin
      n_tests++; if (mon_q[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL basic_data[%0d]: got %0h want %0h", i, mon_q[i], 16'(i + 1)); end
    end
    n_tests++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
    n_tests++; if (fd_idx !== 16 || fd_en !== 1'b1) begin n_fail++; $display("FAIL frame_done_align: beat %0d en %0b want 16/1", fd_idx, fd_en); end
  endtask

  task automatic test_ovf_holdoff();
    bit ok;
    int got;
    int seen = 0;
    int bad  = 0;
    vsyn_fall();
    clr_mon();
    for (int i = 0; i < 40; i++) begin
      if (i < 24) begin
        data_16b    = 16'(16'h0100 + i + 1);
        data_16b_en = 1'b1;
      end else begin
        data_16b_en = 1'b0;
      end
      tick();
      if (i == 15) begin
        n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_at_16: got %0b want 0", ovf_err); end
      end
      if (i == 16) begin
        n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_at_17: got %0b want 1", ovf_err); end
      end
      if (wr_req === 1'b1) begin
        seen++;
        if (wr_addr !== 22'h0) bad++;
      end else if (seen > 0) begin
        bad++;
      end
    end
    data_16b_en = 1'b0;
    n_tests++; if (seen < 20 || bad !== 0) begin n_fail++; $display("FAIL ovf_req_stable: seen %0d bad %0d want >=20/0", seen, bad); end
    n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", ovf_err); end
    ack_burst(8, got);
    wait_req(ok);
    n_tests++; if (ok !== 1'b1 || wr_addr !== 22'h8) begin n_fail++; $display("FAIL ovf_addr2: req %0b addr %0h want 1/8", ok, wr_addr); end
    ack_burst(8, got);
    n_tests++; if (mon_q.size() !== 16) begin n_fail++; $display("FAIL ovf_beats: got %0d want 16", mon_q.size()); end
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (mon_q[i] !== 16'(16'h0100 + i + 1)) begin n_fail++; $display("FAIL ovf_data[%0d]: got %0h want %0h", i, mon_q[i], 16'(16'h0100 + i + 1)); end
    end
    n_tests++; if (ovf_err !== 1'b1 || fd_cnt !== 1) begin n_fail++; $display("FAIL ovf_end: ovf %0b fd %0d want 1/1", ovf_err, fd_cnt); end
  endtask

  task automatic test_vsyn_midburst();
    bit ok;
    int got;
    vsyn_fall();
    clr_mon();
    cmos_vsyn = 1'b1;
    for (int i = 0; i < 12; i++) send_px(16'(16'h0200 + i));
    wait_req(ok);
    n_tests++; if (ok !== 1'b1 || wr_addr !== 22'h0) begin n_fail++; $display("FAIL mid_addr1: req %0b addr %0h want 1/0", ok, wr_addr); end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    tick(3);
    cmos_vsyn = 1'b0;
    tick(20);
    n_tests++; if (mon_q.size() !== 8) begin n_fail++; $display("FAIL mid_beats: got %0d want 8", mon_q.size()); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (mon_q[i] !== 16'(16'h0200 + i)) begin n_fail++; $display("FAIL mid_data[%0d]: got %0h want %0h", i, mon_q[i], 16'(16'h0200 + i)); end
    end
    n_tests++; if (wr_req !== 1'b0 || fd_cnt !== 0) begin n_fail++; $display("FAIL mid_flushed: req %0b fd %0d want 0/0", wr_req, fd_cnt); end
    for (int i = 0; i < 8; i++) send_px(16'(16'h0300 + i));
    wait_req(ok);
    n_tests++; if (ok !== 1'b1 || wr_addr !== 22'h0) begin n_fail++; $display("FAIL mid_addr2: req %0b addr %0h want 1/0", ok, wr_addr); end
    ack_burst(8, got);
    n_tests++; if (got !== 8) begin n_fail++; $display("FAIL mid_beats2: got %0d want 8", got); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (mon_q[8 + i] !== 16'(16'h0300 + i)) begin n_fail++; $display("FAIL mid_data2[%0d]: got %0h want %0h", i, mon_q[8 + i], 16'(16'h0300 + i)); end
    end
  endtask

  task automatic test_reset_midburst();
    bit ok;
    int got;
    int n0;
    vsyn_fall();
    clr_mon();
    for (int i = 0; i < 8; i++) send_px(16'(16'h0400 + i));
    wait_req(ok);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({wr_req, wr_data_en, frame_done, ovf_err} !== 4'b0) begin n_fail++; $display("FAIL rst_mid_flags: req/en/fd/ovf %04b want 0000", {wr_req, wr_data_en, frame_done, ovf_err}); end
    n_tests++; if (wr_addr !== 22'h0 || wr_data !== 16'h0) begin n_fail++; $display("FAIL rst_mid_bus: addr %0h data %0h want 0/0", wr_addr, wr_data); end
    tick(2);
    rst_n = 1'b1;
    n0 = mon_q.size();
    tick(20);
    n_tests++; if (mon_q.size() !== n0 || wr_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet: beats %0d req %0b want 0/0", mon_q.size() - n0, wr_req); end
    vsyn_fall();
    for (int i = 0; i < 8; i++) send_px(16'(16'h0500 + i));
    wait_req(ok);
    n_tests++; if (ok !== 1'b1 || wr_addr !== 22'h0) begin n_fail++; $display("FAIL rst_mid_addr: req %0b addr %0h want 1/0", ok, wr_addr); end
    ack_burst(8, got);
    n_tests++; if (got !== 8) begin n_fail++; $display("FAIL rst_mid_beats: got %0d want 8", got); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (mon_q[n0 + i] !== 16'(16'h0500 + i)) begin n_fail++; $display("FAIL rst_mid_data[%0d]: got %0h want %0h", i, mon_q[n0 + i], 16'(16'h0500 + i)); end
    end
  endtask

`ifdef CAM_PINGPONG_EN
  task automatic pp_burst(input logic [15:0] base, output logic [21:0] addr);
    bit ok;
    int got;
    for (int i = 0; i < 8; i++) send_px(16'(base + 16'(i)));
    wait_req(ok);
    addr = ok ? wr_addr : 22'h3fffff;
    ack_burst(8, got);
  endtask

  task automatic test_pingpong();
    logic [21:0] a0, a1, a2, a3;
    vsyn_fall();
    clr_mon();
    n_tests++; if (wr_bank !== 1'b0) begin n_fail++; $display("FAIL pp_bank0: got %0b want 0", wr_bank); end
    pp_burst(16'h0600, a0);
    pp_burst(16'h0608, a1);
    n_tests++; if (a0 !== 22'h0 || a1 !== 22'h8) begin n_fail++; $display("FAIL pp_f1_addr: %0h/%0h want 0/8", a0, a1); end
    n_tests++; if (wr_bank !== 1'b1 || fd_cnt !== 1) begin n_fail++; $display("FAIL pp_bank1: bank %0b fd %0d want 1/1", wr_bank, fd_cnt); end
    vsyn_fall();
    pp_burst(16'h0700, a2);
    pp_burst(16'h0708, a3);
    n_tests++; if (a2 !== 22'h080000 || a3 !== 22'h080008) begin n_fail++; $display("FAIL pp_f2_addr: %0h/%0h want 80000/80008", a2, a3); end
    n_tests++; if (wr_bank !== 1'b0 || fd_cnt !== 2) begin n_fail++; $display("FAIL pp_bank2: bank %0b fd %0d want 0/2", wr_bank, fd_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_burst();
    test_ovf_holdoff();
    test_vsyn_midburst();
    test_reset_midburst();
`ifdef CAM_PINGPONG_EN
    test_pingpong();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
